// File: rtl/coin_pkg.sv
// Coin acceptor shared definitions.
// Contents: coin codes presented to the vending FSM, debounce channel state encoding,
//           and the same-cycle event merge helper.
package coin_pkg;

    typedef logic [1:0] coin_code_t;

    localparam coin_code_t COIN_NONE = 2'b00;
    localparam coin_code_t COIN_5    = 2'b01;
    localparam coin_code_t COIN_10   = 2'b10;

    // Debounce channel states: IDLE/ARM mean "released", HELD/REL_WAIT mean "pressed".
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        HELD     = 2'd2,
        REL_WAIT = 2'd3
    } chan_state_e;

    // Code to queue for one cycle of channel events; simultaneous events queue nothing.
    function automatic coin_code_t merge_code(input logic ev5, input logic ev10);
        coin_code_t code;
        case ({ev10, ev5})
            2'b01:   code = COIN_5;
            2'b10:   code = COIN_10;
            default: code = COIN_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin slot: 2-flop synchroniser, debounce FSM and stability counter.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-high
//   raw    in  asynchronous raw sensor (high = coin present)
//   ev     out registered 1-cycle pulse per accepted press (event is a reserved word)
module coin_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic ev
);

    localparam int unsigned CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          raw_s;
    chan_state_e   state;
    chan_state_e   state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ev_nxt;

    // Synchroniser, state, counter and event registers.
    // Reset lands in REL_WAIT so a sensor stuck high through reset is treated as still pressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            raw_s <= 1'b0;
            state <= REL_WAIT;
            cnt   <= '0;
            ev    <= 1'b0;
        end else begin
            sync1 <= raw;
            raw_s <= sync1;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ev    <= ev_nxt;
        end
    end

    // Next state: a level change is accepted after DEBOUNCE consecutive stable samples.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ev_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (raw_s) begin
                    state_nxt = ARM;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ARM: begin
                if (!raw_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    ev_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!raw_s) begin
                    state_nxt = REL_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            REL_WAIT: begin
                if (raw_s) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = REL_WAIT;
        endcase
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end for the vending FSM: debounces the 5 and 10 slots, merges
// their events and queues coins in a small FIFO presented one per cycle.
// Ports:
//   clk         in  rising-edge clock
//   reset       in  synchronous, active-high
//   coin5_raw   in  raw 5-unit sensor
//   coin10_raw  in  raw 10-unit sensor
//   sink_busy   in  downstream not consuming this cycle; head is held
//   coin_out    out head coin code (00 when empty), from registered FIFO state
//   fifo_level  out number of queued coins
//   reject      out registered 1-cycle pulse when a coin event was dropped
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coin5_raw,
    input  logic                     coin10_raw,
    input  logic                     sink_busy,
    output logic [1:0]               coin_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     reject
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic          ev5;
    logic          ev10;
    coin_code_t    push_code;
    logic          single;
    logic          both;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          reject_c;
    coin_code_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb5 (
        .clk   (clk),
        .reset (reset),
        .raw   (coin5_raw),
        .ev    (ev5)
    );

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb10 (
        .clk   (clk),
        .reset (reset),
        .raw   (coin10_raw),
        .ev    (ev10)
    );

    // Merge and FIFO control; a pop in the same cycle frees the slot for a push when full.
    always_comb begin
        push_code = merge_code(ev5, ev10);
        single    = ev5 ^ ev10;
        both      = ev5 & ev10;
        empty     = (fifo_level == '0);
        full      = (fifo_level == LW'(DEPTH));
        pop       = !empty && !sink_busy;
        push      = single && (!full || pop);
        reject_c  = both || (single && full && !pop);
    end

    // FIFO storage, pointers (wrap naturally at power-of-2 depth), level and reject pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= COIN_NONE;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            reject     <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_code;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + LW'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LW'(1);
            end
            reject <= reject_c;
        end
    end

    assign coin_out = empty ? COIN_NONE : mem[rd_ptr];

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus randomized sensor and
// sink traffic, compared every cycle against a window-based behavioural model.
module tb_coin_acceptor;

    localparam int unsigned DEBOUNCE = 4;
    localparam int unsigned DEPTH    = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin5_raw = 1'b0;
    logic       coin10_raw = 1'b0;
    logic       sink_busy = 1'b0;
    logic [1:0] coin_out;
    logic [2:0] fifo_level;
    logic       reject;

    int n_vec = 0;
    int n_err = 0;

    coin_acceptor #(.DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .sink_busy  (sink_busy),
        .coin_out   (coin_out),
        .fifo_level (fifo_level),
        .reject     (reject)
    );

    always #5 clk = ~clk;

    // Reference model: per slot, a 2-sample input delay, a window of the last DEBOUNCE
    // synced samples and the debounced level; coins held in a plain queue.
    logic [1:0]          m_fifo [$];
    logic [1:0]          m_rdly [2];
    logic [DEBOUNCE-1:0] m_win  [2];
    int                  m_nval [2];
    logic                m_lvl  [2];
    logic                m_ev   [2];
    logic                m_rej;

    logic [1:0] acc_q [$];
    int         rej_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic r5, input logic r10, input logic busy);
        logic raw [2];
        logic s;
        logic pop;
        raw[0] = r5;
        raw[1] = r10;
        if (rst) begin
            m_fifo.delete();
            m_rej = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                m_rdly[ch] = 2'b00;
                m_win[ch]  = '0;
                m_nval[ch] = 0;
                m_lvl[ch]  = 1'b1;
                m_ev[ch]   = 1'b0;
            end
            return;
        end
        pop   = (m_fifo.size() != 0) && !busy;
        m_rej = 1'b0;
        if (m_ev[0] && m_ev[1]) begin
            m_rej = 1'b1;
        end else if (m_ev[0] || m_ev[1]) begin
            if (m_fifo.size() < int'(DEPTH) || pop) begin
                if (pop) void'(m_fifo.pop_front());
                pop = 1'b0;
                m_fifo.push_back(m_ev[0] ? 2'b01 : 2'b10);
            end else begin
                m_rej = 1'b1;
            end
        end
        if (pop) void'(m_fifo.pop_front());
        for (int ch = 0; ch < 2; ch++) begin
            s          = m_rdly[ch][1];
            m_rdly[ch] = {m_rdly[ch][0], raw[ch]};
            m_win[ch]  = {m_win[ch][DEBOUNCE-2:0], s};
            if (m_nval[ch] < int'(DEBOUNCE)) m_nval[ch]++;
            m_ev[ch] = 1'b0;
            if (m_nval[ch] == int'(DEBOUNCE) && s != m_lvl[ch] &&
                (s ? (&m_win[ch]) : !(|m_win[ch]))) begin
                m_lvl[ch] = s;
                m_ev[ch]  = s;
            end
        end
    endtask

    // One clock: drive inputs, log what the sink takes, advance model, compare outputs.
    task automatic cycle(input logic rst, input logic r5, input logic r10, input logic busy);
        reset      = rst;
        coin5_raw  = r5;
        coin10_raw = r10;
        sink_busy  = busy;
        if (!rst && !busy && coin_out != 2'b00) acc_q.push_back(coin_out);
        @(posedge clk);
        model_step(rst, r5, r10, busy);
        #1;
        check("coin_out", 32'(coin_out), 32'((m_fifo.size() != 0) ? m_fifo[0] : 2'b00));
        check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
        check("reject", 32'(reject), 32'(m_rej));
        if (reject) rej_seen++;
    endtask

    task automatic hold(input int n, input logic r5, input logic r10, input logic busy);
        repeat (n) cycle(1'b0, r5, r10, busy);
    endtask

    task automatic clear_logs();
        acc_q.delete();
        rej_seen = 0;
    endtask

    initial begin
        logic [1:0] a0;
        logic [1:0] a1;
        logic [1:0] a2;
        logic [1:0] a3;
        int   d5;
        int   d10;
        int   db;
        logic l5;
        logic l10;
        logic lb;

        // Reset, then let both channels see a clean low period.
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_out", 32'(coin_out), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        hold(6, 1'b0, 1'b0, 1'b0);

        // Single 5 press.
        clear_logs();
        hold(10, 1'b1, 1'b0, 1'b0);
        hold(10, 1'b0, 1'b0, 1'b0);
        a0 = acc_q[0];
        check("t1_count", 32'(acc_q.size()), 32'd1);
        check("t1_code", 32'(a0), 32'd1);
        check("t1_reject", 32'(rej_seen), 32'd0);

        // Short glitch, then a valid 10 press with chattering release.
        clear_logs();
        hold(3, 1'b0, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b0, 1'b0);
        check("t2_glitch", 32'(acc_q.size()), 32'd0);
        hold(8, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b0, 1'b0, 1'b0);
        hold(1, 1'b0, 1'b1, 1'b0);
        hold(10, 1'b0, 1'b0, 1'b0);
        a0 = acc_q[0];
        check("t2_count", 32'(acc_q.size()), 32'd1);
        check("t2_code", 32'(a0), 32'd2);

        // Head held while the sink is busy.
        clear_logs();
        hold(6, 1'b1, 1'b0, 1'b0);
        hold(1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            hold(1, 1'b0, 1'b0, 1'b1);
            check("t3_held", 32'(coin_out), 32'd1);
        end
        hold(1, 1'b0, 1'b0, 1'b0);
        check("t3_popped", 32'(fifo_level), 32'd0);
        hold(6, 1'b0, 1'b0, 1'b0);
        check("t3_count", 32'(acc_q.size()), 32'd1);

        // Overflow: five alternating coins while busy, then drain in order.
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            hold(6, (i % 2) == 0, (i % 2) == 1, 1'b1);
            hold(6, 1'b0, 1'b0, 1'b1);
        end
        check("t4_full", 32'(fifo_level), 32'd4);
        check("t4_reject", 32'(rej_seen), 32'd1);
        hold(8, 1'b0, 1'b0, 1'b0);
        a0 = acc_q[0];
        a1 = acc_q[1];
        a2 = acc_q[2];
        a3 = acc_q[3];
        check("t4_count", 32'(acc_q.size()), 32'd4);
        check("t4_order", 32'({a0, a1, a2, a3}), 32'b01_10_01_10);

        // Both slots at once.
        clear_logs();
        hold(6, 1'b1, 1'b1, 1'b0);
        hold(8, 1'b0, 1'b0, 1'b0);
        check("t5_reject", 32'(rej_seen), 32'd1);
        check("t5_count", 32'(acc_q.size()), 32'd0);
        check("t5_level", 32'(fifo_level), 32'd0);

        // Reset with coins queued and a sensor stuck high.
        hold(6, 1'b1, 1'b0, 1'b1);
        hold(6, 1'b0, 1'b0, 1'b1);
        hold(6, 1'b0, 1'b1, 1'b1);
        hold(6, 1'b0, 1'b0, 1'b1);
        check("t6_queued", 32'(fifo_level), 32'd2);
        hold(2, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("t6_rst_out", 32'(coin_out), 32'd0);
        check("t6_rst_level", 32'(fifo_level), 32'd0);
        clear_logs();
        hold(12, 1'b1, 1'b0, 1'b0);
        check("t6_stuck", 32'(acc_q.size()), 32'd0);
        hold(6, 1'b0, 1'b0, 1'b0);
        hold(8, 1'b1, 1'b0, 1'b0);
        hold(6, 1'b0, 1'b0, 1'b0);
        a0 = acc_q[0];
        check("t6_count", 32'(acc_q.size()), 32'd1);
        check("t6_code", 32'(a0), 32'd1);

        // Random sensor levels, busy bursts and rare resets.
        d5  = 0;
        d10 = 0;
        db  = 0;
        l5  = 1'b0;
        l10 = 1'b0;
        lb  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (d5 == 0) begin
                l5 = ($urandom_range(0, 1) == 1);
                d5 = int'($urandom_range(1, 12));
            end
            if (d10 == 0) begin
                l10 = ($urandom_range(0, 1) == 1);
                d10 = int'($urandom_range(1, 12));
            end
            if (db == 0) begin
                lb = ($urandom_range(0, 2) == 0);
                db = int'($urandom_range(1, 25));
            end
            d5--;
            d10--;
            db--;
            cycle(($urandom_range(0, 699) == 0), l5, l10, lb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
